// File: rtl/alu_pipe_if.sv
// ============================================================================
// Module   : alu_pipe_if
// Brief    : Valid/ready operand and result bundle for the execute-stage ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in_1;
    logic [WIDTH-1:0] data_in_2;
    logic [5:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             zero;
    logic             illegal_op;

    // Master drives operands and accepts results (forwarding mux / EX-MEM side).
    modport master (
        output in_valid, data_in_1, data_in_2, alu_op, out_ready,
        input  in_ready, out_valid, data_out, zero, illegal_op
    );

    modport slave (
        input  in_valid, data_in_1, data_in_2, alu_op, out_ready,
        output in_ready, out_valid, data_out, zero, illegal_op
    );
endinterface

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// Module   : alu_pipe
// Brief    : Handshaked ALU with iterative shift-add MUL/MULHU and illegal-op flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  wire logic clock,
    input  wire logic reset_n,
    alu_pipe_if.slave bus
);
    localparam int c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_data_out;
    logic                 r_zero;
    logic                 r_illegal;
    logic                 r_out_valid;
    logic                 r_mulhi;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 w_in_ready;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [WIDTH-1:0]     w_result;
    logic                 w_illegal;
    logic                 w_is_mul;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_a        = bus.data_in_1;
    assign w_b        = bus.data_in_2;
    assign w_shamt    = w_b[SHAMT_W-1:0];
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});

    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        w_is_mul  = 1'b0;
        case (bus.alu_op)
            6'd0,  6'd10: w_result = w_a + w_b;
            6'd1:         w_result = w_a - w_b;
            6'd2,  6'd11: w_result = w_a ^ w_b;
            6'd3,  6'd12: w_result = w_a | w_b;
            6'd4,  6'd13: w_result = w_a & w_b;
            6'd5,  6'd14: w_result = w_a << w_shamt;
            6'd6,  6'd15: w_result = w_a >> w_shamt;
            6'd7,  6'd16: w_result = WIDTH'($signed(w_a) >>> w_shamt);
            6'd8,  6'd17: w_result = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            6'd9,  6'd18: w_result = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
            6'd19, 6'd20: w_is_mul = 1'b1;
            default:      w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_data_out  <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
            r_mulhi     <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
        end else if (w_accept) begin
            r_zero    <= (w_a == w_b);
            r_illegal <= w_illegal;
            if (w_is_mul) begin
                r_state     <= ST_MUL;
                r_out_valid <= 1'b0;
                r_mulhi     <= (bus.alu_op == 6'd20);
                r_acc       <= '0;
                r_mcand     <= {{WIDTH{1'b0}}, w_a};
                r_mplier    <= w_b;
                r_cnt       <= '0;
            end else begin
                r_state     <= ST_DONE;
                r_out_valid <= 1'b1;
                r_data_out  <= w_result;
            end
        end else begin
            case (r_state)
                ST_MUL: begin
                    // One multiplier bit per cycle, LSB first; the last step writes the result.
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_data_out  <= r_mulhi ? w_acc_next[2*WIDTH-1:WIDTH]
                                               : w_acc_next[WIDTH-1:0];
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.data_out   = r_data_out;
    assign bus.zero       = r_zero;
    assign bus.illegal_op = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Directed self-checking bench for alu_pipe at WIDTH=32.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_pipe;
    logic clock;
    logic reset_n;
    int   n_vec;
    int   n_bad;
    int   lat;
    logic ir_seen;
    logic [31:0] b2b_a [4];
    logic [31:0] b2b_b [4];
    logic [31:0] b2b_e [4];

    alu_pipe_if #(.WIDTH(32)) bus ();

    alu_pipe #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one op for exactly one edge; caller guarantees in_ready.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid  = 1'b1;
        bus.alu_op    = op;
        bus.data_in_1 = a;
        bus.data_in_2 = b;
        @(posedge clock);
        #1;
        bus.in_valid  = 1'b0;
        bus.data_in_1 = 32'hDEAD_BEEF;
        bus.data_in_2 = 32'hDEAD_BEEF;
    endtask

    // Counts edges after the accept edge until out_valid, noting any in_ready.
    task automatic wait_valid(output int edges, output logic rdy);
        edges = 0;
        rdy   = 1'b0;
        while (!bus.out_valid && edges < 40) begin
            if (bus.in_ready) rdy = 1'b1;
            @(posedge clock);
            #1;
            edges++;
        end
    endtask

    task automatic idle_edge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset_n       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_op    = 6'd0;
        bus.data_in_1 = '0;
        bus.data_in_2 = '0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_data_out", bus.data_out, 32'd0);
        check("rst_zero", {31'b0, bus.zero}, 32'd0);
        check("rst_illegal", {31'b0, bus.illegal_op}, 32'd0);
        idle_edge();
        idle_edge();
        reset_n = 1'b1;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Single-cycle ops, latency 1, consumer always ready
        bus.out_ready = 1'b1;
        issue(6'd0, 32'hFFFF_FFFF, 32'h0000_0002);
        check("add_valid", {31'b0, bus.out_valid}, 32'd1);
        check("add_data", bus.data_out, 32'h0000_0001);
        check("add_zero", {31'b0, bus.zero}, 32'd0);
        check("add_illegal", {31'b0, bus.illegal_op}, 32'd0);
        issue(6'd7, 32'h8000_0000, 32'h0000_0024);
        check("sra", bus.data_out, 32'hF800_0000);
        issue(6'd6, 32'h8000_0000, 32'h0000_0024);
        check("srl", bus.data_out, 32'h0800_0000);
        issue(6'd16, 32'h8000_0000, 32'h0000_001F);
        check("sra_alt", bus.data_out, 32'hFFFF_FFFF);
        issue(6'd8, 32'hFFFF_FFFF, 32'h0000_0001);
        check("slt", bus.data_out, 32'h0000_0001);
        issue(6'd9, 32'hFFFF_FFFF, 32'h0000_0001);
        check("sltu", bus.data_out, 32'h0000_0000);
        issue(6'd1, 32'h0000_0005, 32'h0000_0005);
        check("sub_data", bus.data_out, 32'h0000_0000);
        check("sub_zero", {31'b0, bus.zero}, 32'd1);
        issue(6'd12, 32'hF0F0_0000, 32'h0000_0F0F);
        check("or", bus.data_out, 32'hF0F0_0F0F);
        issue(6'd2, 32'hFF00_FF00, 32'h0FF0_0FF0);
        check("xor", bus.data_out, 32'hF0F0_F0F0);
        issue(6'd4, 32'hFF00_FF00, 32'h0FF0_0FF0);
        check("and", bus.data_out, 32'h0F00_0F00);
        issue(6'd14, 32'h0000_0001, 32'h0000_0021);
        check("sll", bus.data_out, 32'h0000_0002);
        idle_edge();
        check("idle_valid", {31'b0, bus.out_valid}, 32'd0);
        check("idle_ready", {31'b0, bus.in_ready}, 32'd1);

        // MUL with a 3-cycle consumer stall
        bus.out_ready = 1'b0;
        issue(6'd19, 32'h0001_0003, 32'h0002_0005);
        check("mul_ready_after_accept", {31'b0, bus.in_ready}, 32'd0);
        wait_valid(lat, ir_seen);
        check("mul_latency", lat, 32'd32);
        check("mul_in_ready_seen", {31'b0, ir_seen}, 32'd0);
        check("mul_data", bus.data_out, 32'h000B_000F);
        for (int i = 0; i < 3; i++) begin
            idle_edge();
            check("mul_stall_valid", {31'b0, bus.out_valid}, 32'd1);
            check("mul_stall_data", bus.data_out, 32'h000B_000F);
            check("mul_stall_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        idle_edge();
        check("mul_drain_valid", {31'b0, bus.out_valid}, 32'd0);

        issue(6'd20, 32'h0001_0003, 32'h0002_0005);
        wait_valid(lat, ir_seen);
        check("mulhu_latency", lat, 32'd32);
        check("mulhu_data", bus.data_out, 32'h0000_0002);
        idle_edge();

        // Back-to-back single-cycle ADDs
        b2b_a[0] = 32'h0000_0001; b2b_b[0] = 32'h0000_0001; b2b_e[0] = 32'h0000_0002;
        b2b_a[1] = 32'h0000_0010; b2b_b[1] = 32'h0000_0020; b2b_e[1] = 32'h0000_0030;
        b2b_a[2] = 32'hFFFF_FFFF; b2b_b[2] = 32'hFFFF_FFFF; b2b_e[2] = 32'hFFFF_FFFE;
        b2b_a[3] = 32'h0000_0007; b2b_b[3] = 32'h0000_0000; b2b_e[3] = 32'h0000_0007;
        bus.in_valid = 1'b1;
        bus.alu_op   = 6'd10;
        for (int k = 0; k < 4; k++) begin
            bus.data_in_1 = b2b_a[k];
            bus.data_in_2 = b2b_b[k];
            check("b2b_ready_pre", {31'b0, bus.in_ready}, 32'd1);
            @(posedge clock);
            #1;
            check("b2b_valid", {31'b0, bus.out_valid}, 32'd1);
            check("b2b_data", bus.data_out, b2b_e[k]);
        end
        bus.in_valid = 1'b0;
        idle_edge();

        // Asynchronous reset in the middle of a multiply
        issue(6'd19, 32'h0000_0003, 32'h0000_0005);
        for (int i = 0; i < 9; i++) idle_edge();
        #2 reset_n = 1'b0;
        #1;
        check("midmul_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midmul_rst_data", bus.data_out, 32'd0);
        idle_edge();
        reset_n = 1'b1;
        check("midmul_rst_ready", {31'b0, bus.in_ready}, 32'd1);
        issue(6'd40, 32'h0000_0005, 32'h0000_0005);
        check("illegal_valid", {31'b0, bus.out_valid}, 32'd1);
        check("illegal_data", bus.data_out, 32'd0);
        check("illegal_flag", {31'b0, bus.illegal_op}, 32'd1);
        issue(6'd0, 32'h0000_0001, 32'h0000_0002);
        check("illegal_cleared", {31'b0, bus.illegal_op}, 32'd0);
        check("post_illegal_add", bus.data_out, 32'h0000_0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
